// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed hex display controller for an N-digit common-anode
// 7-segment display: per-digit value register file, refresh prescaler,
// automatic scan, per-digit blanking, decimal point, PWM brightness and
// a frame pulse.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   wr_en      write strobe for the digit register file
//   wr_sel     digit index to write (out-of-range indices are ignored)
//   wr_num     hex value to store
//   wr_dp      decimal point for that digit, 1 = lit
//   blank      per-digit blank, 1 = digit dark (sampled live)
//   bright     brightness, 0 = 1/16 duty, 15 = full (sampled live)
//   segment    cathodes a..g on bits 0..6, active-low
//   dp         decimal-point cathode, active-low
//   anode      digit enables, active-low, at most one low
//   frame_tick one-cycle pulse at the start of each full scan
module seg7_scan_ctrl #(
    parameter int unsigned N_DIGITS = 8,
    parameter int unsigned DIV      = 100000,
    localparam int unsigned SEL_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [SEL_W-1:0]    wr_sel,
    input  logic [3:0]          wr_num,
    input  logic                wr_dp,
    input  logic [N_DIGITS-1:0] blank,
    input  logic [3:0]          bright,
    output logic [6:0]          segment,
    output logic                dp,
    output logic [N_DIGITS-1:0] anode,
    output logic                frame_tick
);

    localparam int unsigned CNT_W = $clog2(DIV);
    // (bright+1) <= 16 needs 5 bits on top of the slot counter width
    localparam int unsigned LIM_W = CNT_W + 5;

    logic [CNT_W-1:0]    cnt;
    logic [SEL_W-1:0]    idx;
    logic [3:0]          num_reg [N_DIGITS];
    logic [N_DIGITS-1:0] dp_reg;
    logic                started;

    logic                cnt_wrap_c;
    logic                idx_last_c;
    logic [LIM_W-1:0]    on_limit_c;
    logic                lit_c;

    // Active-low gfedcba hex decode
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        s = 7'h7F;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Slot timing and PWM gate
    always_comb begin
        cnt_wrap_c = (cnt == CNT_W'(DIV - 1));
        idx_last_c = (idx == SEL_W'(N_DIGITS - 1));
        on_limit_c = ((LIM_W'(bright) + LIM_W'(1)) * LIM_W'(DIV)) >> 4;
        lit_c      = (LIM_W'(cnt) < on_limit_c) && !blank[idx];
    end

    // Prescaler and digit scan; started gates frame_tick until the first full scan
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx     <= '0;
            started <= 1'b0;
        end else begin
            if (cnt_wrap_c) begin
                cnt <= '0;
                idx <= idx_last_c ? '0 : idx + SEL_W'(1);
                if (idx_last_c) begin
                    started <= 1'b1;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Digit register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_DIGITS); i++) begin
                num_reg[i] <= 4'h0;
            end
            dp_reg <= '0;
        end else if (wr_en && (32'(wr_sel) < N_DIGITS)) begin
            num_reg[wr_sel] <= wr_num;
            dp_reg[wr_sel]  <= wr_dp;
        end
    end

    // Output register; a single register for anode keeps digits from overlapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode      <= '1;
            segment    <= 7'h7F;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            anode      <= lit_c ? ~(N_DIGITS'(1) << idx) : '1;
            segment    <= lit_c ? decode(num_reg[idx]) : 7'h7F;
            dp         <= lit_c ? ~dp_reg[idx] : 1'b1;
            frame_tick <= started && (cnt == '0) && (idx == '0);
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: three instances (8 digits/DIV 16, 8 digits/DIV 32,
// 6 digits/DIV 16) share stimulus; an arithmetic model of the scan is checked
// every cycle, plus literal expectations that pin the model.
module tb_seg7_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en;
    logic [2:0] wr_sel;
    logic [3:0] wr_num;
    logic       wr_dp;
    logic [7:0] blank;
    logic [3:0] bright;

    logic [6:0] seg_a, seg_b, seg_c;
    logic       dp_a, dp_b, dp_c;
    logic [7:0] anode_a, anode_b;
    logic [5:0] anode_c;
    logic       ft_a, ft_b, ft_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.N_DIGITS(8), .DIV(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_num(wr_num),
        .wr_dp(wr_dp), .blank(blank), .bright(bright), .segment(seg_a), .dp(dp_a),
        .anode(anode_a), .frame_tick(ft_a)
    );

    seg7_scan_ctrl #(.N_DIGITS(8), .DIV(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_num(wr_num),
        .wr_dp(wr_dp), .blank(blank), .bright(bright), .segment(seg_b), .dp(dp_b),
        .anode(anode_b), .frame_tick(ft_b)
    );

    seg7_scan_ctrl #(.N_DIGITS(6), .DIV(16)) dut_c (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_num(wr_num),
        .wr_dp(wr_dp), .blank(blank[5:0]), .bright(bright), .segment(seg_c), .dp(dp_c),
        .anode(anode_c), .frame_tick(ft_c)
    );

    logic [15:0] an_act  [3];
    logic [6:0]  seg_act [3];
    logic        dp_act  [3];
    logic        ft_act  [3];

    assign an_act[0]  = 16'(anode_a);
    assign an_act[1]  = 16'(anode_b);
    assign an_act[2]  = 16'(anode_c);
    assign seg_act[0] = seg_a;
    assign seg_act[1] = seg_b;
    assign seg_act[2] = seg_c;
    assign dp_act[0]  = dp_a;
    assign dp_act[1]  = dp_b;
    assign dp_act[2]  = dp_c;
    assign ft_act[0]  = ft_a;
    assign ft_act[1]  = ft_b;
    assign ft_act[2]  = ft_c;

    function automatic int ndig(input int i);
        return (i == 2) ? 6 : 8;
    endfunction

    function automatic int divv(input int i);
        return (i == 1) ? 32 : 16;
    endfunction

    function automatic logic [15:0] amask(input int i);
        return 16'((32'd1 << ndig(i)) - 32'd1);
    endfunction

    function automatic logic [6:0] seg_tab(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[v];
    endfunction

    task automatic chk(input string nm, input int inst, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d t=%0t got=%0h want=%0h", nm, inst, $time, act, exp);
        end
    endtask

    // Model state: states elapsed since reset release, plus shadow register files
    int          s_cnt [3];
    logic [3:0]  mnum  [3][16];
    logic        mdp   [3][16];
    logic [15:0] e_an  [3];
    logic [6:0]  e_seg [3];
    logic        e_dp  [3];
    logic        e_ft  [3];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int  n, d, cnt, idx, lim;
            bit  lit;
            n = ndig(i);
            d = divv(i);
            if (!rst_n) begin
                e_an[i]  = amask(i);
                e_seg[i] = 7'h7F;
                e_dp[i]  = 1'b1;
                e_ft[i]  = 1'b0;
            end
            chk("anode", i, an_act[i], e_an[i]);
            chk("segment", i, 16'(seg_act[i]), 16'(e_seg[i]));
            chk("dp", i, 16'(dp_act[i]), 16'(e_dp[i]));
            chk("frame_tick", i, 16'(ft_act[i]), 16'(e_ft[i]));
            if (!rst_n) begin
                s_cnt[i] = 0;
                for (int j = 0; j < 16; j++) begin
                    mnum[i][j] = 4'h0;
                    mdp[i][j]  = 1'b0;
                end
            end else begin
                // Expected outputs after the coming edge, from the state index alone
                cnt = s_cnt[i] % d;
                idx = (s_cnt[i] / d) % n;
                lim = ((int'(bright) + 1) * d) / 16;
                lit = (cnt < lim) && !blank[idx[2:0]];
                e_an[i]  = lit ? (amask(i) & ~(16'd1 << idx)) : amask(i);
                e_seg[i] = lit ? seg_tab(mnum[i][idx[3:0]]) : 7'h7F;
                e_dp[i]  = lit ? ~mdp[i][idx[3:0]] : 1'b1;
                e_ft[i]  = (s_cnt[i] > 0) && (s_cnt[i] % (n * d) == 0);
                if (wr_en && (int'(wr_sel) < n)) begin
                    mnum[i][wr_sel] = wr_num;
                    mdp[i][wr_sel]  = wr_dp;
                end
                s_cnt[i]++;
            end
        end
    end

    // Bounded wait on an output value; sel 0 = anode_a, 1 = anode_c, 2 = frame_tick_c
    task automatic wait_for(input int sel, input logic [7:0] v, input int budget);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            case (sel)
                0:       ok = (anode_a === v);
                1:       ok = (8'(anode_c) === v);
                default: ok = (8'(ft_c) === v);
            endcase
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait sel=%0d t=%0t got=timeout want=%0h", sel, $time, v);
        end
    endtask

    task automatic write_digit(input int sel, input logic [3:0] num, input logic dpv);
        @(posedge clk); #1;
        wr_en  = 1'b1;
        wr_sel = 3'(sel);
        wr_num = num;
        wr_dp  = dpv;
        @(posedge clk); #1;
        wr_en  = 1'b0;
    endtask

    initial begin
        int c_dp, c_fb, c_ff, c_lit, per;

        wr_en = 1'b0; wr_sel = '0; wr_num = '0; wr_dp = 1'b0; blank = '0; bright = 4'hF;
        rst_n = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            wr_en  = 1'($urandom_range(0, 1));
            wr_sel = 3'($urandom_range(0, 7));
            wr_num = 4'($urandom_range(0, 15));
            wr_dp  = 1'($urandom_range(0, 1));
            blank  = 8'($urandom_range(0, 255));
            bright = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        chk("rst_anode", 0, 16'(anode_a), 16'h00FF);
        chk("rst_segment", 0, 16'(seg_a), 16'h007F);
        chk("rst_dp", 0, 16'(dp_a), 16'h1);
        chk("rst_ft", 0, 16'(ft_a), 16'h0);

        @(posedge clk); #1;
        wr_en = 1'b0; wr_sel = '0; wr_num = '0; wr_dp = 1'b0; blank = '0; bright = 4'hF;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("first_anode", 0, 16'(anode_a), 16'h00FE);
        chk("first_segment", 0, 16'(seg_a), 16'h0040);

        for (int k = 0; k < 8; k++) write_digit(k, 4'(k), 1'b0);
        repeat (260) @(posedge clk);
        wait_for(0, 8'hF7, 200);
        chk("digit3_is_3", 0, 16'(seg_a), 16'h0030);

        for (int k = 0; k < 8; k++) write_digit(k, 4'(k + 8), 1'b0);
        repeat (10) @(posedge clk);
        wait_for(0, 8'hF7, 200);
        chk("digit3_is_B", 0, 16'(seg_a), 16'h0003);

        // Decimal point on digit 5, digit 2 blanked
        blank = 8'b0000_0100;
        write_digit(5, 4'hD, 1'b1);
        repeat (2) @(posedge clk);
        c_dp = 0; c_fb = 0; c_ff = 0;
        for (int n = 0; n < 128; n++) begin
            @(negedge clk);
            if (dp_a == 1'b0) c_dp++;
            if (anode_a == 8'hFB) c_fb++;
            if (anode_a == 8'hFF) c_ff++;
        end
        chk("dp_low_cycles", 0, 16'(c_dp), 16'd16);
        chk("blank_slot_lit", 0, 16'(c_fb), 16'd0);
        chk("blank_slot_dark", 0, 16'(c_ff), 16'd16);

        // Brightness on the DIV=32 instance
        @(posedge clk); #1;
        blank = '0; bright = 4'd3;
        @(posedge clk);
        c_lit = 0;
        for (int n = 0; n < 256; n++) begin
            @(negedge clk);
            if (anode_b != 8'hFF) c_lit++;
        end
        chk("bright3_lit", 1, 16'(c_lit), 16'd64);
        @(posedge clk); #1;
        bright = 4'd0;
        @(posedge clk);
        c_lit = 0;
        for (int n = 0; n < 256; n++) begin
            @(negedge clk);
            if (anode_b != 8'hFF) c_lit++;
        end
        chk("bright0_lit", 1, 16'(c_lit), 16'd16);
        @(posedge clk); #1;
        bright = 4'hF;

        // Frame period on the 6-digit instance
        wait_for(2, 8'h01, 250);
        chk("ft_anode", 2, 16'(anode_c), 16'h003E);
        per = 0;
        for (int n = 0; n < 250; n++) begin
            @(negedge clk);
            per++;
            if (ft_c == 1'b1) break;
        end
        chk("ft_period", 2, 16'(per), 16'd96);

        // Out-of-range write for the 6-digit instance
        write_digit(7, 4'h9, 1'b0);
        repeat (5) @(posedge clk);
        wait_for(1, 8'h1F, 250);
        chk("oor_seg_keep", 2, 16'(seg_c), 16'h0021);
        chk("oor_dp_keep", 2, 16'(dp_c), 16'h0);

        // Asynchronous reset between edges during slot 4
        wait_for(0, 8'hEF, 200);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_anode", 0, 16'(anode_a), 16'h00FF);
        chk("async_segment", 0, 16'(seg_a), 16'h007F);
        chk("async_dp", 0, 16'(dp_a), 16'h1);
        chk("async_anode_c", 2, 16'(anode_c), 16'h003F);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("restart_anode", 0, 16'(anode_a), 16'h00FE);
        chk("restart_segment", 0, 16'(seg_a), 16'h0040);
        wait_for(0, 8'hFD, 40);
        chk("restart_seg_d1", 0, 16'(seg_a), 16'h0040);

        repeat (20) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed hex display controller for an N-digit common-anode 7-segment display.
- Successor to the single-digit combinational decoder: adds a per-digit value register file with a write port, a refresh prescaler, an automatic scan, per-digit blanking, a decimal point, PWM brightness and a frame pulse.
- Sits between the board's seven-segment pins and any core that wants to show hex values.

Parameters:
- N_DIGITS, 8, number of digits scanned (2..16); SEL_W = max(1, clog2(N_DIGITS)) is derived, not overridable.
- DIV, 100000, clock cycles per digit slot (>=16).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe for the digit register file.
- wr_sel  in  SEL_W  digit index to write.
- wr_num  in  4  hex value to store.
- wr_dp  in  1  decimal point for that digit, 1 = lit.
- blank  in  N_DIGITS  per-digit blank, 1 = digit dark.
- bright  in  4  brightness, 0 = 1/16 duty, 15 = full.
- segment  out  7  cathodes, active-low; bit0 = a … bit6 = g.
- dp  out  1  decimal-point cathode, active-low.
- anode  out  N_DIGITS  digit enables, active-low, at most one low.
- frame_tick  out  1  one-cycle pulse at the start of each full scan.

Behaviour:
- Reset (async, rst_n=0):
  - num_reg[*]=0, dp_reg[*]=0, cnt=0, idx=0.
  - anode=all 1s, segment=7'h7F, dp=1, frame_tick=0.
- Register file:
  - On a rising clk edge with wr_en=1 and wr_sel<N_DIGITS: num_reg[wr_sel]<=wr_num and dp_reg[wr_sel]<=wr_dp.
  - wr_sel>=N_DIGITS: write is ignored, no state changes.
- Prescaler:
  - cnt counts 0..DIV-1 and wraps to 0.
  - On the wrap, idx <= (idx==N_DIGITS-1) ? 0 : idx+1.
- Brightness:
  - on_limit = ((bright+1)*DIV)>>4, computed at a width that cannot overflow.
  - lit = (cnt < on_limit) && !blank[idx].
  - bright=15 gives on_limit=DIV, i.e. lit for the whole slot.
  - bright and blank are sampled live, with no latching.
- Output stage (registered, one cycle after the cnt/idx state):
  - anode <= lit ? ~(1<<idx) : all 1s.
  - segment <= lit ? decode(num_reg[idx]) : 7'h7F.
  - dp <= lit ? ~dp_reg[idx] : 1.
- Decode, active-low gfedcba:
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
  - 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E (hex).
- frame_tick:
  - Registered pulse, high for exactly one cycle.
  - Asserted in the output cycle corresponding to cnt=0, idx=0, i.e. every N_DIGITS*DIV cycles.
  - The first pulse appears only after the first idx wrap. It is not asserted on reset release.
- Timing boundaries:
  - A write to the digit currently lit is visible on segment two edges after the write edge (register update, then output register).
  - A write to a different digit appears at that digit's next slot.
  - Write coinciding with the cnt wrap: the write and the scan advance both take effect; neither blocks the other.
  - A blank or bright change mid-slot affects outputs from the next edge.
- Reset mid-operation clears everything immediately (async), independent of clk.
- anode never has more than one bit low, including across slot boundaries: transitions go through the single output register, so there is no overlap.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles with random inputs -> anode=8'hFF, segment=7'h7F, dp=1, frame_tick=0; release -> first anode=8'hFE appears after 1 clk.
- Decode and scan (N_DIGITS=8, DIV=16, bright=15, blank=0):
  - Write digit k = value k for k=0..7, then digits 0..7 = 8..F.
  - Each slot k -> anode=~(1<<k) for 16 cycles.
  - segment matches the decode table for both passes, e.g. digit 3 = 3 gives 7'h30; digit 3 = B gives 7'h03.
- dp and blank: wr_dp=1 on digit 5; blank=8'b0000_0100 -> dp=0 only during slot 5; slot 2 shows anode=8'hFF, segment=7'h7F for all 16 cycles.
- Brightness (DIV=32): bright=3 -> on_limit=8, so each slot is lit for cycles 1..8 after slot start and dark for 24; bright=0 -> lit for 2 cycles per slot.
- frame_tick and range (N_DIGITS=6, DIV=16):
  - frame_tick pulses exactly every 96 cycles, coincident with anode=6'b111110.
  - wr_en with wr_sel=7 -> no register changes.
- Async reset mid-scan: assert rst_n=0 between clk edges during slot 4 -> outputs go to reset values without a clk edge; after release the scan restarts at idx 0 and num_reg reads 0 (segment 7'h40 on lit digits).
